// File: rtl/add_sub_if.sv
// add_sub_if: operand/mode inputs and registered result/flag outputs of the add/sub block
interface add_sub_if #(parameter int WIDTH = 4);
  logic             M;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] S;
  logic             carryout;
  logic             overflow;
  modport master (output M, X, Y, input S, carryout, overflow);
  modport slave (input M, X, Y, output S, carryout, overflow);
endinterface

// File: rtl/add_sub.sv
// add_sub: registered ripple-carry two's-complement adder/subtractor
module add_sub #(parameter int WIDTH = 4) (
  input logic    clk,
  input logic    rst,
  add_sub_if.slave bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_d, s_q;
  logic             co_q, ov_q;
  assign c[0] = bus.M;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic b;
    assign b        = bus.Y[i] ^ bus.M;
    assign s_d[i]   = bus.X[i] ^ b ^ c[i];
    assign c[i+1]   = (bus.X[i] & b) | (c[i] & (bus.X[i] ^ b));
  end
  // capture result and flags each edge; async reset clears them
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_q  <= '0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= c[WIDTH];
      ov_q <= c[WIDTH] ^ c[WIDTH-1];
    end
  assign bus.S        = s_q;
  assign bus.carryout = co_q;
  assign bus.overflow = ov_q;
endmodule

// File: tb/tb_add_sub.sv
// tb_add_sub: random and directed checking of add_sub against an arithmetic model
module tb_add_sub;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  add_sub_if #(.WIDTH(W)) bus();
  add_sub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q;
  function automatic logic [W+1:0] ref_op(logic m, logic [W-1:0] x, logic [W-1:0] y);
    int ux = x;
    int uy = y;
    int sx = $signed(x);
    int sy = $signed(y);
    int r = m ? sx - sy : sx + sy;
    logic cy = m ? (ux >= uy) : (ux + uy > (1 << W) - 1);
    logic v = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    logic [W-1:0] s = m ? x - y : x + y;
    return {cy, v, s};
  endfunction
  task automatic chk(string n, logic [W+1:0] act, logic [W+1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {co,ov,S}=%b want %b at %0t", n, act, exp, $time);
    end
  endtask
  // expected outputs: sampled inputs evaluated arithmetically, cleared by reset
  always @(posedge clk or posedge rst)
    if (rst) exp_q <= '0;
    else exp_q <= ref_op(bus.M, bus.X, bus.Y);
  always @(negedge clk) chk("model", {bus.carryout, bus.overflow, bus.S}, exp_q);
  task automatic drive(logic m, logic [W-1:0] x, logic [W-1:0] y);
    @(posedge clk);
    #2;
    bus.M = m;
    bus.X = x;
    bus.Y = y;
  endtask
  task automatic dir(string n, logic m, logic [W-1:0] x, logic [W-1:0] y, logic [W+1:0] exp);
    drive(m, x, y);
    @(posedge clk);
    #1 chk(n, {bus.carryout, bus.overflow, bus.S}, exp);
  endtask
  task automatic rand_burst(int n);
    for (int k = 0; k < n; k++)
      drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
  endtask
  initial begin
    bus.M = 1'b0;
    bus.X = '0;
    bus.Y = '0;
    #1 chk("reset", {bus.carryout, bus.overflow, bus.S}, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    dir("add_5_3", 1'b0, 4'b0101, 4'b0011, 6'b01_1000);
    dir("sub_5_3", 1'b1, 4'b0101, 4'b0011, 6'b10_0010);
    dir("sub_3_5", 1'b1, 4'b0011, 4'b0101, 6'b00_1110);
    dir("wrap", 1'b0, 4'b1111, 4'b0001, 6'b10_0000);
    dir("sub_ovf", 1'b1, 4'b0010, 4'b1000, 6'b01_1010);
    dir("sub_eq", 1'b1, 4'b0101, 4'b0101, 6'b10_0000);
    dir("add_neg", 1'b0, 4'b1000, 4'b1000, 6'b11_0000);
    rand_burst(300);
    drive(1'b0, 4'b0001, 4'b0001);
    @(posedge clk);
    #1 chk("pre_rst", {bus.carryout, bus.overflow, bus.S}, 6'b00_0010);
    #2 rst = 1'b1;
    #1 chk("async_rst", {bus.carryout, bus.overflow, bus.S}, '0);
    @(posedge clk);
    #1 chk("held_rst", {bus.carryout, bus.overflow, bus.S}, '0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst", {bus.carryout, bus.overflow, bus.S}, 6'b00_0010);
    rand_burst(200);
    for (int k = 0; k < 5; k++) begin
      rand_burst(20);
      #1 rst = 1'b1;
      #1 chk("mid_rst", {bus.carryout, bus.overflow, bus.S}, '0);
      @(posedge clk);
      #2 rst = 1'b0;
    end
    rand_burst(50);
    @(posedge clk);
    @(negedge clk);
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
